// File: rtl/lcd_text_scheduler.sv
// Round-robin scheduler sharing one lcd_init text sender among three requesters.
// Latches request pulses, holds the granted text stable and paces transfers with a timeout and an idle gap.
module lcd_text_scheduler #(
  parameter int TEXT_BITS      = 272,
  parameter int GAP_CYCLES     = 50000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [2:0]           req,
  input  logic [TEXT_BITS-1:0] text0,
  input  logic [TEXT_BITS-1:0] text1,
  input  logic [TEXT_BITS-1:0] text2,
  input  logic                 sending_done,
  output logic                 send_text,
  output logic [TEXT_BITS-1:0] text_out,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [2:0]           done,
  output logic                 timeout
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SEND = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           pending;
  logic [2:0]           clr;
  logic [1:0]           winner;
  logic [CNT_W-1:0]     cnt;
  logic [TEXT_BITS-1:0] sel_text;

  // First pending index after the last grant, wrapping 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    idx     = (last == 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!found && p[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  endfunction

  always_comb begin
    winner   = rr_pick(pending, grant_id);
    clr      = (state == S_LOAD) ? (3'b001 << winner) : 3'b000;
    sel_text = text0;
    case (winner)
      2'd1:    sel_text = text1;
      2'd2:    sel_text = text2;
      default: sel_text = text0;
    endcase
  end

  assign send_text = (state == S_SEND);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      pending  <= 3'b000;
      text_out <= '0;
      grant_id <= 2'd2;
      done     <= 3'b000;
      timeout  <= 1'b0;
      cnt      <= '0;
    end else begin
      done    <= 3'b000;
      timeout <= 1'b0;
      // A request arriving on the clearing edge re-queues its requester.
      pending <= (pending & ~clr) | req;
      case (state)
        S_IDLE: if (|pending) state <= S_LOAD;
        S_LOAD: begin
          text_out <= sel_text;
          grant_id <= winner;
          state    <= S_SEND;
        end
        S_SEND: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (sending_done) begin
            done  <= 3'b001 << grant_id;
            cnt   <= '0;
            state <= S_GAP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // The acknowledge cycle plus GAP_CYCLES idle cycles.
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
